// File: rtl/alu_seq_pkg.sv
// Shared types and 8-bit ALU control encodings for the multi-byte ALU sequencer.
// Imported by alu_seq_ctrl and by anything that decodes its ALU drive.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OpAdd = 3'b000,
        OpSub = 3'b001,
        OpAnd = 3'b010,
        OpOr  = 3'b011,
        OpXor = 3'b100,
        OpNot = 3'b101,
        OpCnt = 3'b110,
        OpMov = 3'b111
    } seq_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } seq_state_e;

    // ALU Type field
    localparam logic [1:0] TYPE_MATH   = 2'b00;
    localparam logic [1:0] TYPE_ASSIGN = 2'b10;
    localparam logic [1:0] TYPE_VALUE  = 2'b11;

    // ALU M_op field (math group)
    localparam logic [2:0] M_ADD = 3'b000;
    localparam logic [2:0] M_AND = 3'b010;
    localparam logic [2:0] M_OR  = 3'b011;
    localparam logic [2:0] M_XOR = 3'b100;
    localparam logic [2:0] M_NOT = 3'b111;

    // ALU A_op / V_op fields
    localparam logic [2:0] A_CNTR = 3'b001;
    localparam logic       V_MOV  = 1'b0;

    function automatic logic is_arith(seq_op_e op);
        return (op == OpAdd) || (op == OpSub);
    endfunction

endpackage

// File: rtl/alu_seq_ctrl.sv
// Multi-byte operation sequencer: drives an external 8-bit ALU one byte per cycle, LSB first,
// chaining carry between bytes and assembling the wide result.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int unsigned NBYTES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [2:0]            op_i,
    input  logic [8*NBYTES-1:0]   a_i,
    input  logic [8*NBYTES-1:0]   b_i,
    input  logic                  cin_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [8*NBYTES-1:0]   result_o,
    output logic                  carry_o,
    output logic                  zero_o,
    output logic [1:0]            alu_type_o,
    output logic [2:0]            alu_mop_o,
    output logic [1:0]            alu_cop_o,
    output logic [2:0]            alu_aop_o,
    output logic                  alu_vop_o,
    output logic [7:0]            alu_ina_o,
    output logic [7:0]            alu_inb_o,
    output logic                  alu_sci_o,
    input  logic [7:0]            alu_rslt_i,
    input  logic                  alu_sco_i
);

    localparam int unsigned W    = 8 * NBYTES;
    localparam int unsigned IdxW = $clog2(NBYTES + 1);
    localparam int unsigned CntW = $clog2(W + 1);

    seq_state_e          state_q, state_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    seq_op_e             op_q, op_d;
    logic [W-1:0]        a_q, a_d;
    logic [W-1:0]        b_q, b_d;
    logic                cin_q, cin_d;
    logic                chain_q, chain_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [W-1:0]        result_q, result_d;
    logic                carry_q, carry_d;
    logic                zero_q, zero_d;

    logic                accept;
    logic                first_byte;
    logic                last_byte;
    logic [7:0]          a_byte;
    logic [7:0]          b_byte;
    logic [CntW-1:0]     cnt_sum;
    logic [W-1:0]        res_next;

    assign accept     = start_i && (state_q != StRun);
    assign first_byte = (idx_q == '0);
    assign last_byte  = (idx_q == IdxW'(NBYTES - 1));

    always_comb begin
        a_byte = '0;
        b_byte = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx_q == IdxW'(i)) begin
                a_byte = a_q[i*8 +: 8];
                b_byte = b_q[i*8 +: 8];
            end
        end
    end

    // ALU drive is purely a function of the registered state; idle pattern yields rslt = 0.
    always_comb begin
        alu_type_o = TYPE_VALUE;
        alu_mop_o  = '0;
        alu_cop_o  = 2'b00;
        alu_aop_o  = '0;
        alu_vop_o  = V_MOV;
        alu_ina_o  = '0;
        alu_inb_o  = '0;
        alu_sci_o  = 1'b0;
        if (state_q == StRun) begin
            alu_ina_o = a_byte;
            alu_inb_o = b_byte;
            unique case (op_q)
                OpAdd: begin
                    alu_type_o = TYPE_MATH;
                    alu_mop_o  = M_ADD;
                    alu_sci_o  = first_byte ? cin_q : chain_q;
                end
                OpSub: begin
                    alu_type_o = TYPE_MATH;
                    alu_mop_o  = M_ADD;
                    alu_inb_o  = ~b_byte;
                    alu_sci_o  = first_byte ? 1'b1 : chain_q;
                end
                OpAnd: begin
                    alu_type_o = TYPE_MATH;
                    alu_mop_o  = M_AND;
                end
                OpOr: begin
                    alu_type_o = TYPE_MATH;
                    alu_mop_o  = M_OR;
                end
                OpXor: begin
                    alu_type_o = TYPE_MATH;
                    alu_mop_o  = M_XOR;
                end
                OpNot: begin
                    alu_type_o = TYPE_MATH;
                    alu_mop_o  = M_NOT;
                end
                OpCnt: begin
                    alu_type_o = TYPE_ASSIGN;
                    alu_aop_o  = A_CNTR;
                end
                OpMov: begin
                    alu_type_o = TYPE_VALUE;
                    alu_vop_o  = V_MOV;
                end
            endcase
        end
    end

    // Result as it will stand after this cycle's byte is captured.
    always_comb begin
        cnt_sum  = cnt_q + CntW'(alu_rslt_i);
        res_next = result_q;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx_q == IdxW'(i)) begin
                res_next[i*8 +: 8] = alu_rslt_i;
            end
        end
        if (op_q == OpCnt) begin
            res_next = W'(cnt_sum);
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        cin_d    = cin_q;
        chain_d  = chain_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                chain_d = alu_sco_i;
                cnt_d   = cnt_sum;
                if (op_q != OpCnt) begin
                    result_d = res_next;
                end
                if (last_byte) begin
                    state_d  = StDone;
                    idx_d    = '0;
                    result_d = res_next;
                    carry_d  = is_arith(op_q) ? alu_sco_i : 1'b0;
                    zero_d   = (res_next == '0);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                state_d = accept ? StRun : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (accept) begin
            idx_d   = '0;
            op_d    = seq_op_e'(op_i);
            a_d     = a_i;
            b_d     = b_i;
            cin_d   = cin_i;
            chain_d = 1'b0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            op_q     <= OpAdd;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            chain_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cin_q    <= cin_d;
            chain_q  <= chain_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
        end
    end

    assign busy_o   = (state_q == StRun);
    assign done_o   = (state_q == StDone);
    assign result_o = result_q;
    assign carry_o  = carry_q;
    assign zero_o   = zero_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl (NBYTES=2) with a behavioural 8-bit ALU peer and a wide-arithmetic
// reference model.
module tb_alu_seq_ctrl;

    localparam int unsigned NB = 2;

    logic           clk;
    logic           rst_n;
    logic           start_i;
    logic [2:0]     op_i;
    logic [15:0]    a_i;
    logic [15:0]    b_i;
    logic           cin_i;
    logic           busy_o;
    logic           done_o;
    logic [15:0]    result_o;
    logic           carry_o;
    logic           zero_o;
    logic [1:0]     alu_type;
    logic [2:0]     alu_mop;
    logic [1:0]     alu_cop;
    logic [2:0]     alu_aop;
    logic           alu_vop;
    logic [7:0]     alu_ina;
    logic [7:0]     alu_inb;
    logic           alu_sci;
    logic [7:0]     alu_rslt;
    logic           alu_sco;

    int total = 0;
    int bad   = 0;

    alu_seq_ctrl #(.NBYTES(NB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .op_i       (op_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .cin_i      (cin_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .carry_o    (carry_o),
        .zero_o     (zero_o),
        .alu_type_o (alu_type),
        .alu_mop_o  (alu_mop),
        .alu_cop_o  (alu_cop),
        .alu_aop_o  (alu_aop),
        .alu_vop_o  (alu_vop),
        .alu_ina_o  (alu_ina),
        .alu_inb_o  (alu_inb),
        .alu_sci_o  (alu_sci),
        .alu_rslt_i (alu_rslt),
        .alu_sco_i  (alu_sco)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 8-bit ALU peer.
    always_comb begin
        logic [8:0] s;
        s        = 9'(alu_ina) + 9'(alu_inb) + 9'(alu_sci);
        alu_rslt = 8'h00;
        alu_sco  = 1'b0;
        case (alu_type)
            2'b00: begin
                case (alu_mop)
                    3'b000: {alu_sco, alu_rslt} = s;
                    3'b010: alu_rslt = alu_ina & alu_inb;
                    3'b011: alu_rslt = alu_ina | alu_inb;
                    3'b100: alu_rslt = alu_ina ^ alu_inb;
                    3'b111: alu_rslt = ~alu_ina;
                    default: alu_rslt = 8'h00;
                endcase
            end
            2'b10: if (alu_aop == 3'b001) alu_rslt = 8'($countones(alu_ina));
            2'b11: if (alu_vop == 1'b0) alu_rslt = alu_ina;
            default: alu_rslt = 8'h00;
        endcase
    end

    // Reference: {carry, result} from whole-word arithmetic.
    function automatic logic [16:0] ref_calc(input logic [2:0] op, input logic [15:0] a,
                                             input logic [15:0] b, input logic cin);
        logic [16:0] r;
        case (op)
            3'd0: r = 17'(a) + 17'(b) + 17'(cin);
            3'd1: r = {(a >= b), a - b};
            3'd2: r = {1'b0, a & b};
            3'd3: r = {1'b0, a | b};
            3'd4: r = {1'b0, a ^ b};
            3'd5: r = {1'b0, ~a};
            3'd6: r = {1'b0, 16'($countones(a))};
            default: r = {1'b0, a};
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input string tag);
        logic [16:0] exp;
        logic [8:0]  lo;
        logic        sci0;
        logic        sci1;
        exp  = ref_calc(op, a, b, cin);
        lo   = 9'(a[7:0]) + 9'(b[7:0]) + 9'(cin);
        sci0 = (op == 3'd0) ? cin : (op == 3'd1);
        sci1 = (op == 3'd0) ? lo[8] : (op == 3'd1) ? (a[7:0] >= b[7:0]) : 1'b0;
        @(negedge clk);
        start_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        cin_i   = cin;
        @(posedge clk);
        #1 start_i = 1'b0;
        check($sformatf("%s busy idx0", tag), busy_o, 1);
        check($sformatf("%s sci idx0", tag), alu_sci, sci0);
        @(posedge clk);
        #1;
        check($sformatf("%s busy idx1", tag), busy_o, 1);
        check($sformatf("%s sci idx1", tag), alu_sci, sci1);
        check($sformatf("%s early done", tag), done_o, 0);
        @(posedge clk);
        #1;
        check($sformatf("%s done", tag), done_o, 1);
        check($sformatf("%s busy at done", tag), busy_o, 0);
        check($sformatf("%s result", tag), result_o, exp[15:0]);
        check($sformatf("%s carry", tag), carry_o, exp[16]);
        check($sformatf("%s zero", tag), zero_o, (exp[15:0] == 16'h0));
    endtask

    initial begin
        logic [16:0] e1;
        logic [16:0] e2;
        int          dones;
        start_i = 1'b0;
        op_i    = 3'd0;
        a_i     = '0;
        b_i     = '0;
        cin_i   = 1'b0;
        rst_n   = 1'b0;
        #12;
        check("reset busy", busy_o, 0);
        check("reset done", done_o, 0);
        check("reset result", result_o, 0);
        check("reset carry", carry_o, 0);
        check("reset zero", zero_o, 1);
        check("reset type", alu_type, 2'b11);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(3'd0, 16'h00FF, 16'h0001, 1'b0, "add1");
        run_op(3'd0, 16'hFFFF, 16'h0001, 1'b0, "add2");
        run_op(3'd1, 16'h1234, 16'h1235, 1'b0, "sub1");
        run_op(3'd1, 16'h1235, 16'h1234, 1'b0, "sub2");
        run_op(3'd6, 16'hF00F, 16'h0000, 1'b0, "cnt");
        run_op(3'd4, 16'hA5A5, 16'hFFFF, 1'b0, "xor");
        run_op(3'd7, 16'hBEEF, 16'h1234, 1'b1, "mov");
        run_op(3'd5, 16'h0F0F, 16'h0000, 1'b0, "not");
        run_op(3'd0, 16'h7FFF, 16'h8000, 1'b1, "addcin");

        for (int i = 0; i < 30; i++) begin
            run_op(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 1'($urandom),
                   $sformatf("rnd%0d", i));
        end

        // Back-to-back: start held high through DONE.
        e1 = ref_calc(3'd0, 16'h1111, 16'h2222, 1'b0);
        e2 = ref_calc(3'd1, 16'h0005, 16'h0007, 1'b0);
        @(negedge clk);
        start_i = 1'b1;
        op_i    = 3'd0;
        a_i     = 16'h1111;
        b_i     = 16'h2222;
        cin_i   = 1'b0;
        @(posedge clk);
        #1;
        op_i = 3'd1;
        a_i  = 16'h0005;
        b_i  = 16'h0007;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("b2b done1", done_o, 1);
        check("b2b result1", result_o, e1[15:0]);
        @(posedge clk);
        #1 start_i = 1'b0;
        check("b2b busy reassert", busy_o, 1);
        check("b2b no done", done_o, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("b2b done2", done_o, 1);
        check("b2b result2", result_o, e2[15:0]);
        check("b2b carry2", carry_o, e2[16]);

        // Start pulse during RUN is ignored.
        e1 = ref_calc(3'd3, 16'h0F00, 16'h00F0, 1'b0);
        @(negedge clk);
        start_i = 1'b1;
        op_i    = 3'd3;
        a_i     = 16'h0F00;
        b_i     = 16'h00F0;
        @(posedge clk);
        #1;
        op_i = 3'd7;
        a_i  = 16'hDEAD;
        @(posedge clk);
        #1 start_i = 1'b0;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            if (done_o) dones++;
            @(posedge clk);
            #1;
        end
        check("ignore done count", dones, 1);
        check("ignore result", result_o, e1[15:0]);

        // Reset mid-RUN after idx0.
        @(negedge clk);
        start_i = 1'b1;
        op_i    = 3'd0;
        a_i     = 16'h00FF;
        b_i     = 16'h00FF;
        @(posedge clk);
        #1 start_i = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mrst busy", busy_o, 0);
        check("mrst done", done_o, 0);
        check("mrst result", result_o, 0);
        check("mrst carry", carry_o, 0);
        check("mrst zero", zero_o, 1);
        check("mrst ina", alu_ina, 0);
        check("mrst sci", alu_sci, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'd0, 16'h00FF, 16'h00FF, 1'b1, "post rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
